// File: rtl/packet_serializer.sv
// Transmit-side packet serializer: one message per handshake becomes an 8-byte header
// (LE length, LE stream, LE sequence) followed by payload, emitted as 32-bit words.
module packet_serializer #(
  parameter int MAX_PAYLOAD = 40,
  parameter int STREAM_W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*MAX_PAYLOAD-1:0] msg_data,
  input  logic [15:0]              msg_len,
  input  logic [STREAM_W-1:0]      msg_stream,
  input  logic                     msg_skip,
  input  logic                     msg_val,
  output logic                     msg_ready,
  output logic [31:0]              dataOut,
  output logic                     dataOut_val,
  input  logic                     dataOut_ready,
  output logic                     dataOut_last,
  output logic                     err_len
);

  localparam int DW      = 8 * MAX_PAYLOAD;
  localparam int NSTREAM = 2 ** STREAM_W;

  // state | meaning
  // IDLE  | ready for a message; msg_ready high
  // HDR0  | presenting length/stream header word
  // HDR1  | presenting sequence-number header word
  // PAY   | presenting payload words, words_q counts down to the final one
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         data_q, data_d, data_masked;
  logic [15:0]           len_q, len_d;
  logic [15:0]           words_q, words_d;
  logic [STREAM_W-1:0]   stream_q, stream_d;
  logic [31:0]           seq_q, seq_d;
  logic                  err_q, err_d;
  logic [31:0]           ctr_q [NSTREAM];
  logic                  ctr_we;
  logic [15:0]           tot_len;
  logic [15:0]           stream_w;

  assign tot_len  = len_q + 16'd8;
  assign stream_w = {{(16-STREAM_W){1'b0}}, stream_q};
  assign err_len  = err_q;

  // Bytes past msg_len are cleared at capture so a partial final word pads with zeros.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (16'(i) < msg_len) begin
        data_masked[DW-1-8*i -: 8] = msg_data[DW-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    len_d        = len_q;
    words_d      = words_q;
    stream_d     = stream_q;
    seq_d        = seq_q;
    err_d        = 1'b0;
    ctr_we       = 1'b0;
    msg_ready    = 1'b0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    dataOut      = '0;
    unique case (state_q)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_val) begin
          if (msg_len > 16'(MAX_PAYLOAD)) begin
            err_d = 1'b1;
          end else begin
            data_d   = data_masked;
            len_d    = msg_len;
            words_d  = (msg_len + 16'd3) >> 2;
            stream_d = msg_stream;
            seq_d    = ctr_q[msg_stream] + {31'b0, msg_skip};
            state_d  = HDR0;
          end
        end
      end
      HDR0: begin
        dataOut_val = 1'b1;
        dataOut     = {tot_len[7:0], tot_len[15:8], stream_w[7:0], stream_w[15:8]};
        if (dataOut_ready) state_d = HDR1;
      end
      HDR1: begin
        dataOut_val  = 1'b1;
        dataOut      = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
        dataOut_last = (words_q == 16'd0);
        if (dataOut_ready) begin
          if (words_q == 16'd0) begin
            ctr_we  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAY;
          end
        end
      end
      PAY: begin
        dataOut_val  = 1'b1;
        dataOut      = data_q[DW-1 -: 32];
        dataOut_last = (words_q == 16'd1);
        if (dataOut_ready) begin
          data_d  = data_q << 32;
          words_d = words_q - 16'd1;
          if (words_q == 16'd1) begin
            ctr_we  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      len_q    <= '0;
      words_q  <= '0;
      stream_q <= '0;
      seq_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      words_q  <= words_d;
      stream_q <= stream_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
    end
  end

  // Sequence counters move only when the final word of a packet is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTREAM; i++) ctr_q[i] <= '0;
    end else if (ctr_we) begin
      ctr_q[stream_q] <= seq_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Randomized bench for packet_serializer; expected words come from a byte-stream model.
module tb_packet_serializer;

  localparam int MAXP = 40;
  localparam int SW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [8*MAXP-1:0] msg_data;
  logic [15:0]       msg_len;
  logic [SW-1:0]     msg_stream;
  logic              msg_skip;
  logic              msg_val;
  logic              msg_ready;
  logic [31:0]       dataOut;
  logic              dataOut_val;
  logic              dataOut_ready;
  logic              dataOut_last;
  logic              err_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  pay   [MAXP];
  logic [31:0] ctr_m [2**SW];

  packet_serializer #(.MAX_PAYLOAD(MAXP), .STREAM_W(SW)) dut (
    .clk(clk), .reset(reset),
    .msg_data(msg_data), .msg_len(msg_len), .msg_stream(msg_stream),
    .msg_skip(msg_skip), .msg_val(msg_val), .msg_ready(msg_ready),
    .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
    .dataOut_last(dataOut_last), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fill_payload();
    for (int i = 0; i < MAXP; i++) pay[i] = 8'($urandom);
  endtask

  // mode 0: always ready, 1: ready toggles every 3 cycles, 2: random ready
  task automatic send_pkt(input int stream, input int len, input bit skip,
                          input int mode, input int abort_after);
    logic [7:0]  b [$];
    logic [31:0] exp_w [$];
    logic [31:0] seq;
    logic [15:0] tl, s16;
    logic [31:0] hold_w;
    logic        hold_l, stalled;
    int          idx, cyc, nw;

    seq = ctr_m[stream] + 32'(skip);
    tl  = 16'(len + 8);
    s16 = 16'(stream);
    b = {};
    b.push_back(tl[7:0]);   b.push_back(tl[15:8]);
    b.push_back(s16[7:0]);  b.push_back(s16[15:8]);
    b.push_back(seq[7:0]);  b.push_back(seq[15:8]);
    b.push_back(seq[23:16]); b.push_back(seq[31:24]);
    for (int i = 0; i < len; i++) b.push_back(pay[i]);
    while (b.size() % 4 != 0) b.push_back(8'h00);
    exp_w = {};
    for (int k = 0; k < b.size() / 4; k++)
      exp_w.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
    nw = exp_w.size();

    @(negedge clk);
    for (int i = 0; i < MAXP; i++) msg_data[8*MAXP-1-8*i -: 8] = pay[i];
    msg_len    = 16'(len);
    msg_stream = SW'(stream);
    msg_skip   = skip;
    msg_val    = 1'b1;
    chk("accept_ready", 32'(msg_ready), 32'd1);
    @(negedge clk);
    msg_val  = 1'b0;
    msg_skip = 1'b0;
    chk("latency1_val", 32'(dataOut_val), 32'd1);
    chk("busy_not_ready", 32'(msg_ready), 32'd0);

    idx = 0; cyc = 0; stalled = 1'b0; hold_w = '0; hold_l = 1'b0;
    while (idx < nw && cyc < 400) begin
      case (mode)
        0: dataOut_ready = 1'b1;
        1: dataOut_ready = ((cyc / 3) % 2) == 1;
        default: dataOut_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (stalled) begin
        chk("stall_hold_word", dataOut, hold_w);
        chk("stall_hold_last", 32'(dataOut_last), 32'(hold_l));
      end
      if (dataOut_val && dataOut_ready) begin
        chk("word", dataOut, exp_w[idx]);
        chk("last", 32'(dataOut_last), 32'(idx == nw - 1));
        idx++;
        if (abort_after >= 0 && idx == abort_after) begin
          @(posedge clk);
          #2 reset = 1'b1;
          #1;
          chk("abort_val", 32'(dataOut_val), 32'd0);
          chk("abort_ready", 32'(msg_ready), 32'd1);
          chk("abort_data", dataOut, 32'd0);
          for (int i = 0; i < 2**SW; i++) ctr_m[i] = '0;
          @(negedge clk);
          reset = 1'b0;
          dataOut_ready = 1'b1;
          return;
        end
      end
      stalled = dataOut_val && !dataOut_ready;
      hold_w  = dataOut;
      hold_l  = dataOut_last;
      cyc++;
      @(negedge clk);
    end
    chk("words_done", 32'(idx), 32'(nw));
    chk("gap_val", 32'(dataOut_val), 32'd0);
    chk("gap_ready", 32'(msg_ready), 32'd1);
    dataOut_ready = 1'b1;
    ctr_m[stream] = seq + 32'd1;
  endtask

  task automatic send_bad(input int stream, input int len);
    @(negedge clk);
    msg_len    = 16'(len);
    msg_stream = SW'(stream);
    msg_skip   = 1'b0;
    msg_val    = 1'b1;
    @(negedge clk);
    msg_val = 1'b0;
    chk("err_pulse", 32'(err_len), 32'd1);
    chk("err_no_val", 32'(dataOut_val), 32'd0);
    chk("err_ready", 32'(msg_ready), 32'd1);
    @(negedge clk);
    chk("err_one_cycle", 32'(err_len), 32'd0);
    chk("err_still_idle", 32'(dataOut_val), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    msg_data = '0; msg_len = '0; msg_stream = '0; msg_skip = 1'b0; msg_val = 1'b0;
    dataOut_ready = 1'b1;
    for (int i = 0; i < 2**SW; i++) ctr_m[i] = '0;
    #1;
    chk("rst_ready", 32'(msg_ready), 32'd1);
    chk("rst_val", 32'(dataOut_val), 32'd0);
    chk("rst_last", 32'(dataOut_last), 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    fill_payload();
    send_pkt(12, 12, 1'b0, 0, -1);
    send_pkt(12, 12, 1'b0, 0, -1);
    send_pkt(13, 8, 1'b0, 0, -1);
    fill_payload();
    send_pkt(5, 13, 1'b0, 0, -1);
    send_pkt(3, 20, 1'b0, 1, -1);
    send_pkt(14, 4, 1'b1, 0, -1);
    send_pkt(14, 0, 1'b0, 1, -1);
    send_pkt(9, 40, 1'b0, 1, -1);
    send_bad(14, 41);
    send_pkt(14, 6, 1'b0, 0, -1);
    fill_payload();
    send_pkt(7, 24, 1'b0, 0, 4);
    send_pkt(7, 5, 1'b0, 0, -1);
    send_pkt(14, 3, 1'b0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      fill_payload();
      if ($urandom_range(0, 9) == 0)
        send_bad($urandom_range(0, 15), $urandom_range(41, 300));
      else
        send_pkt($urandom_range(0, 15), $urandom_range(0, MAXP),
                 ($urandom_range(0, 3) == 0), 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
